// File: rtl/knap_enum_search.sv
// -----------------------------------------------------------------------------
// knap_enum_search
//   Exhaustive search over every selection of N_ITEMS knapsack items. One
//   candidate selection is evaluated per clock against a minimum total value,
//   a maximum total weight and a maximum total volume. The engine keeps the
//   highest-value feasible selection and counts how many selections are
//   feasible.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cfg_we/cfg_idx    item-table write (accepted only while idle)
//   cfg_value/weight/volume  item data written on cfg_we
//   min_value         feasible needs total value  >= min_value
//   max_weight        feasible needs total weight <= max_weight
//   max_volume        feasible needs total volume <= max_volume
//   start             launch a search from idle
//   busy/cand_valid   high while candidates are being enumerated
//   done              one-cycle pulse after the last candidate
//   cand              selection under evaluation (bit i = item i)
//   found/best_sel/best_value  best feasible selection so far
//   feas_count        number of feasible selections
// -----------------------------------------------------------------------------
module knap_enum_search #(
  parameter int N_ITEMS = 7,
  parameter int W       = 8,
  parameter int SUM_W   = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(N_ITEMS)-1:0]   cfg_idx,
  input  logic [W-1:0]                 cfg_value,
  input  logic [W-1:0]                 cfg_weight,
  input  logic [W-1:0]                 cfg_volume,
  input  logic [W-1:0]                 min_value,
  input  logic [W-1:0]                 max_weight,
  input  logic [W-1:0]                 max_volume,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [N_ITEMS-1:0]           cand,
  output logic                         cand_valid,
  output logic                         found,
  output logic [N_ITEMS-1:0]           best_sel,
  output logic [SUM_W-1:0]             best_value,
  output logic [N_ITEMS:0]             feas_count
);

  localparam int IDX_W = $clog2(N_ITEMS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t r_state, w_next_state;

  logic [W-1:0]       r_val [N_ITEMS];
  logic [W-1:0]       r_wgt [N_ITEMS];
  logic [W-1:0]       r_vol [N_ITEMS];

  logic [N_ITEMS-1:0] r_cand;
  logic               r_found;
  logic [N_ITEMS-1:0] r_best_sel;
  logic [SUM_W-1:0]   r_best_value;
  logic [N_ITEMS:0]   r_feas_count;

  logic [SUM_W-1:0]   w_tv, w_tw, w_tvol;
  logic               w_feasible;
  logic               w_better;
  logic               w_last;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM: next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:              w_next_state = S_IDLE;
      default:             w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign cand_valid = busy;

  // ---------------------------------------------------------------------------
  // Candidate totals: zero-extended to SUM_W so multi-item sums never wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_tv   = '0;
    w_tw   = '0;
    w_tvol = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (r_cand[i]) begin
        w_tv   = w_tv   + SUM_W'(r_val[i]);
        w_tw   = w_tw   + SUM_W'(r_wgt[i]);
        w_tvol = w_tvol + SUM_W'(r_vol[i]);
      end
    end
  end

  assign w_feasible = (w_tv   >= SUM_W'(min_value))  &&
                      (w_tw   <= SUM_W'(max_weight)) &&
                      (w_tvol <= SUM_W'(max_volume));
  // Strict '>' keeps the earliest selection on a value tie.
  assign w_better   = w_feasible && (!r_found || (w_tv > r_best_value));
  assign w_last     = (r_cand == {N_ITEMS{1'b1}});

  // ---------------------------------------------------------------------------
  // Item table: writable only while idle, frozen during a search.
  // ---------------------------------------------------------------------------
  // NOTE: the table is small and must read as zero after reset, so it is
  // built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        r_val[i] <= '0;
        r_wgt[i] <= '0;
        r_vol[i] <= '0;
      end
    end else if (r_state == S_IDLE && cfg_we) begin
      // Indices with no matching entry (>= N_ITEMS) write nothing.
      for (int i = 0; i < N_ITEMS; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          r_val[i] <= cfg_value;
          r_wgt[i] <= cfg_weight;
          r_vol[i] <= cfg_volume;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Enumeration and result tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand       <= '0;
      r_found      <= 1'b0;
      r_best_sel   <= '0;
      r_best_value <= '0;
      r_feas_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Previous results stay visible until the next launch.
          if (start) begin
            r_cand       <= '0;
            r_found      <= 1'b0;
            r_best_sel   <= '0;
            r_best_value <= '0;
            r_feas_count <= '0;
          end
        end
        S_RUN: begin
          r_cand <= r_cand + N_ITEMS'(1);
          if (w_feasible) r_feas_count <= r_feas_count + (N_ITEMS + 1)'(1);
          if (w_better) begin
            r_best_sel   <= r_cand;
            r_best_value <= w_tv;
            r_found      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cand       = r_cand;
  assign found      = r_found;
  assign best_sel   = r_best_sel;
  assign best_value = r_best_value;
  assign feas_count = r_feas_count;

endmodule

// File: doc/knap_enum_search.md
Name: knap_enum_search

Overview:
- Sequential exhaustive-search engine for the 7-item, 3-constraint knapsack (value / weight / volume).
- Holds a loadable item table and steps through all 2^N_ITEMS selection vectors, one per clock.
- Checks each vector against the min-value, max-weight and max-volume limits.
- Reports the best feasible selection and the feasible count.
- Drives each candidate vector on cand so a downstream combinational validity checker can be co-simulated against it.

Parameters:
- N_ITEMS, 7, number of items; selection vector width.
- W, 8, width of each item value/weight/volume and of each limit.
- SUM_W, 11, accumulator width (W + ceil(log2(N_ITEMS))); sums never wrap.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  item-table write strobe
- cfg_idx  in  3  item index 0..N_ITEMS-1; bit i of a selection = item i
- cfg_value  in  W  item value
- cfg_weight  in  W  item weight
- cfg_volume  in  W  item volume
- min_value  in  W  feasibility: total value >= min_value
- max_weight  in  W  feasibility: total weight <= max_weight
- max_volume  in  W  feasibility: total volume <= max_volume
- start  in  1  begin a search (single-cycle pulse or level)
- busy  out  1  high while enumerating
- done  out  1  one-cycle pulse when the search completes
- cand  out  N_ITEMS  selection currently evaluated
- cand_valid  out  1  cand is meaningful this cycle (equals busy)
- found  out  1  at least one feasible selection seen
- best_sel  out  N_ITEMS  best feasible selection
- best_value  out  SUM_W  total value of best_sel
- feas_count  out  N_ITEMS+1  number of feasible selections

Behaviour:
- Reset: FSM to IDLE.
  - busy, done, cand_valid, found = 0.
  - cand, best_sel, best_value, feas_count = 0.
  - All item table entries = 0.
  - Reset mid-search aborts with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - cfg_we writes entry cfg_idx on the clock edge.
  - cfg_idx >= N_ITEMS is ignored.
  - start=1 -> RUN next cycle. On that same edge: cand<=0, found<=0, best_sel<=0, best_value<=0, feas_count<=0.
  - Results of the previous search stay visible until the next start.
- RUN:
  - busy=1, cand_valid=1.
  - Each cycle, totals for cand are computed combinationally from the table in SUM_W bits, zero-extended, with no truncation.
  - feasible = (tv >= min_value) && (tw <= max_weight) && (tvol <= max_volume). Limits are zero-extended to SUM_W.
  - If feasible: feas_count increments.
  - If feasible and (!found || tv > best_value): best_sel<=cand, best_value<=tv, found<=1.
  - Ties keep the earlier (lower-index) selection.
  - cand increments each cycle. When cand == 2^N_ITEMS-1 is evaluated -> DONE.
- DONE: done=1 for exactly one cycle, busy=0, then -> IDLE.
- Latency: start sampled at edge k -> cand=0 visible cycle k+1 -> last candidate at cycle k+128 -> done high at cycle k+129. Total 129 cycles from start to done.
- While busy:
  - start and cfg_we are ignored; the table is frozen.
  - Limit inputs must be held stable by the user. Sampling is per cycle.
- start asserted in the DONE cycle is ignored. A start held high re-launches from IDLE on the following cycle.
- feas_count max is 128 and fits N_ITEMS+1 bits.
- Selection 0 (empty set) is evaluated: tv=tw=tvol=0, feasible iff min_value==0.

Test Plan:
- Reset mid-run: start, assert rst at cycle 40 -> busy=0, feas_count=0, best_sel=0, no done pulse. Table is zeroed; a fresh start with all-zero table and min_value=0 gives feas_count=128.
- Reference load:
  - Items (value/weight/volume): 0:4/28/27, 1:8/8/27, 2:0/27/4, 3:20/18/4, 4:10/27/0, 5:12/28/24, 6:18/6/4.
  - Limits: min=58, maxw=60, maxvol=60.
  - Expect: done 129 cycles after start, found=1, best_sel=7'h6A, best_value=58, feas_count=1.
- Same table, min_value=0 -> best_value=58, best_sel=7'h6A. feas_count equals the bench-model count of selections with weight<=60 and volume<=60.
- Infeasible: same table, min_value=255 -> found=0, best_sel=0, best_value=0, feas_count=0, done still pulses.
- Tie-break: all items value=5, weight=volume=0, limits min=0/max=255 -> best_value=35, best_sel=7'h7F, feas_count=128. Then set all values 0 -> best_sel=0 (first tie kept).
- No-wrap: all items value=weight=volume=255, maxw=maxvol=255, min=255 -> feas_count=7 (single-item sets only), best_sel=7'h01, best_value=255. An 8-bit-wrapping sum would wrongly accept some multi-item sets.
- Protocol: cfg_we and start pulses during RUN -> table unchanged, search not restarted, exactly one done.
